serial_addsub_ctrl: RTL
=======================

Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer that time-shares one `full_adder` instance across WIDTH-bit operands.
- Processes one bit per cycle, LSB first, and returns a WIDTH-bit two's-complement result with carry-out and signed overflow.
- Sits between a requester (start/done handshake) and the single-bit adder datapath. Replaces the ripple chain when area matters more than latency.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse/level; accepted only when not busy
- op  input  1  0 = A+B, 1 = A−B; sampled with start
- a_in  input  WIDTH  operand A; sampled with start
- b_in  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result; held stable from done until the next accepted start
- cout  output  1  final carry-out (sub: 1 = no borrow)
- ovf  output  1  signed overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Bit counter=0, internal carry=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - When start=1 at a rising edge: load the A shift register with a_in; load the B shift register with b_in (or ~b_in if op=1); set carry=op; counter=0; go to RUN.
- RUN:
  - busy=1.
  - Each cycle drives the full adder with A=a_sr[0], B=b_sr[0], Cin=carry.
  - At each edge: the S bit shifts into sum from the MSB side; a_sr/b_sr shift right; carry<=Cout; counter++.
  - The sign bits of the effective operands and the result are tracked for overflow.
  - After WIDTH RUN cycles (counter==WIDTH−1 at the edge): go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - sum holds the full result; cout=final carry.
  - ovf=(sign_a==sign_b_eff)&&(sum[WIDTH−1]!=sign_a).
  - Next state is IDLE. If start=1 in this cycle, it is accepted and the next state is RUN, allowing back-to-back operation.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while in RUN: ignored (not queued); operands are not resampled.
- Outputs sum/cout/ovf are updated only at the RUN→DONE transition and are held through IDLE.
- Reset asserted mid-RUN: the operation is aborted, all outputs are cleared, and no done pulse is produced.
- Arithmetic: modulo 2^WIDTH. Subtraction is A + ~B + 1; the +1 is injected via the initial carry.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when ovf=1, sum is replaced at RUN→DONE by the signed saturation value. That value is 0111…1 if sign_a=0, else 1000…0. ovf still reports 1, and cout is unchanged.
- Undefined: sum is the wrapped modulo result and no saturation logic is present.

Decomposition:
- Package addsub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Op constants OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module: instantiate the existing `full_adder` (ports A, B, Cin, S, Cout) once as the shared datapath. There is no other sub-module; the FSM, shift registers and counter stay in serial_addsub_ctrl.

Test Plan (WIDTH=4, period 20 ns):
- op=0, a=0011, b=0101: done after 5 edges, sum=1000, cout=0, ovf=1. With ADDSUB_SAT_EN: sum=0111.
- op=1, a=0111, b=0010: sum=0101, cout=1, ovf=0.
- op=1, a=0010, b=0111: sum=1011, cout=0, ovf=0.
- op=1, a=1000, b=0001: sum=0111, cout=1, ovf=1. With ADDSUB_SAT_EN: sum=1000.
- start held high continuously, with operands changed during RUN: results reflect only the values sampled at acceptance; done pulses every 5 cycles; busy is low only in the DONE cycle.
- rst_n pulsed low at cycle 2 of RUN: busy, done, sum, cout and ovf go to 0 immediately; no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: state encoding and op codes for serial_addsub_ctrl
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit adder shared by the serial add/subtract datapath
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: LSB-first bit-serial add/sub over one full_adder; ADDSUB_SAT_EN saturates on overflow
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             carry, s, c, last, accept, ovf_n;
    logic [WIDTH-1:0] a_sr, b_sr, nxt, res;
    logic [WIDTH-2:0] acc;

    full_adder u_fa (.A(a_sr[0]), .B(b_sr[0]), .Cin(carry), .S(s), .Cout(c));

    always_comb begin
        busy    = state == RUN;
        done    = state == DONE;
        last    = (state == RUN) && (cnt == CW'(WIDTH - 1));
        accept  = start && (state != RUN);
        state_n = accept ? RUN : last ? DONE : (state == DONE) ? IDLE : state;
    end

    // On the last RUN cycle a_sr[0]/b_sr[0] are the sign bits of the effective operands
    always_comb begin
        nxt   = {s, acc};
        ovf_n = (a_sr[0] == b_sr[0]) && (s != a_sr[0]);
`ifdef ADDSUB_SAT_EN
        res   = ovf_n ? {a_sr[0], {(WIDTH-1){~a_sr[0]}}} : nxt;
`else
        res   = nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a_in;
            b_sr  <= (op == OP_SUB) ? ~b_in : b_in;
            carry <= op == OP_SUB;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            acc   <= nxt[WIDTH-1:1];
            carry <= c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= res;
                cout <= c;
                ovf  <= ovf_n;
            end
        end
    end
endmodule
